// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - bin and the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result a-b
// presented as a WIDTH+1 bit two's complement value with the borrow as sign.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   d
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   d_q, d_d;

    logic fs_diff;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = {fs_diff, res_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                cnt_d    = cnt_q - CW'(1);
                // Last bit: the published result only changes here, never mid-run.
                if (cnt_q == CW'(1)) begin
                    d_d     = {fs_bout, fs_diff, res_q[WIDTH-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign d    = d_q;

endmodule
